scoreboard_hazard_unit: RTL

Parametrised, stateful successor to the ID-stage hazard detector. It tracks, per architectural register, how many cycles remain before an in-flight result becomes forwardable. Instruction classes have different latencies: ALU, load and multi-cycle multiply/divide. It stalls IF/ID on RAW and WAW hazards, flushes on redirect, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/scoreboard_hazard_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/scoreboard_hazard_unit.sv
// Per-register latency scoreboard for the ID stage.
// Stalls on RAW/WAW, flushes on redirect, counts stall cycles.
module scoreboard_hazard_unit #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 3,
  parameter int ALU_LAT     = 1,
  parameter int LOAD_LAT    = 2,
  parameter int MUL_LAT     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Valid_ID,
  input  logic [REG_ADDR_W-1:0]  Rs_ID,
  input  logic [REG_ADDR_W-1:0]  Rt_ID,
  input  logic                   RsUsed_ID,
  input  logic                   RtUsed_ID,
  input  logic [REG_ADDR_W-1:0]  Rd_ID,
  input  logic                   RegWrite_ID,
  input  logic [1:0]             Class_ID,
  input  logic                   Branch_ID,
  input  logic                   Flush_Req,
  output logic                   PCWrite,
  output logic                   IF_ID_Write,
  output logic                   FlushControl,
  output logic [STALL_CNT_W-1:0] Stall_Cycles
);

  logic [CNT_W-1:0] cnt [1:NUM_REGS-1];

  logic [CNT_W-1:0] rs_cnt;
  logic [CNT_W-1:0] rt_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] th;
  logic             raw;
  logic             waw;
  logic             stall;
  logic             issue;
  logic             rd_nz;

  // r0 and out-of-range indices match no entry and read as 0
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    rd_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (Rs_ID == REG_ADDR_W'(r)) rs_cnt = cnt[r];
      if (Rt_ID == REG_ADDR_W'(r)) rt_cnt = cnt[r];
      if (Rd_ID == REG_ADDR_W'(r)) rd_cnt = cnt[r];
    end
  end

  always_comb begin
    case (Class_ID)
      2'b01:   lat = CNT_W'(LOAD_LAT);
      2'b10:   lat = CNT_W'(MUL_LAT);
      default: lat = CNT_W'(ALU_LAT);
    endcase
  end

  // branches compare in ID, others consume in EX one cycle later
  assign th    = Branch_ID ? '0 : CNT_W'(1);
  assign rd_nz = (Rd_ID != '0);

  assign raw = Valid_ID &&
               ((RsUsed_ID && (rs_cnt > th)) ||
                (RtUsed_ID && (rt_cnt > th)));

  assign waw = Valid_ID && RegWrite_ID && rd_nz &&
               (rd_cnt > lat);

  assign stall = (raw || waw) && !Flush_Req;
  assign issue = Valid_ID && !stall && !Flush_Req;

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    FlushControl = 1'b0;
    if (Flush_Req) begin
      FlushControl = 1'b1;
    end else if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      FlushControl = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 1; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && RegWrite_ID && Rd_ID == REG_ADDR_W'(r))
          cnt[r] <= lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Stall_Cycles <= '0;
    else if (stall && (Stall_Cycles != '1))
      Stall_Cycles <= Stall_Cycles + STALL_CNT_W'(1);
  end

endmodule
